// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths and sequencer states for the BCD converter front end
package bcd_pkg;
  localparam int NDIGITS = 11;
  localparam int BIN_W   = 36;
  localparam int BCD_W   = NDIGITS * 4;

  typedef enum logic [1:0] {IDLE, LOAD, CONVERT, CAPTURE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; pointer moves away from each winner
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);
  logic r_ptr;

  // r_ptr names the requester that wins a tie
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_req[0] && (!i_req[1] || !r_ptr)) o_grant = 2'b01;
      else if (i_req[1])                    o_grant = 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)            r_ptr <= 1'b0;
    else if (o_grant != 2'b00) r_ptr <= o_grant[0];
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - grants the shared binary-to-BCD converter and sequences one conversion
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int LOAD_CYCLES = 2,
  parameter int CONV_CYCLES = 38,
  parameter int CNT_W       = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             req0,
  input  logic [BIN_W-1:0] data0,
  input  logic             req1,
  input  logic [BIN_W-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [BCD_W-1:0] result,
  output logic             busy,
  output logic             conv_enable,
  output logic [BIN_W-1:0] conv_data,
  input  logic [BCD_W-1:0] conv_bcd
);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_owner, w_owner_nxt;
  logic [1:0]       r_ack, w_ack_nxt;
  logic [1:0]       r_done, w_done_nxt;
  logic [BCD_W-1:0] r_result, w_result_nxt;
  logic             r_busy;
  logic             r_conv_en, w_conv_en_nxt;
  logic [BIN_W-1:0] r_conv_data, w_conv_data_nxt;
  logic [1:0]       w_grant;

  rr_arb2 u_arb (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_en    (r_state == IDLE),
    .i_req   ({req1, req0}),
    .o_grant (w_grant)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_ack_nxt       = 2'b00;
    w_done_nxt      = 2'b00;
    w_result_nxt    = r_result;
    w_conv_en_nxt   = r_conv_en;
    w_conv_data_nxt = r_conv_data;
    case (r_state)
      IDLE: begin
        if (w_grant != 2'b00) begin
          w_ack_nxt       = w_grant;
          w_owner_nxt     = w_grant[1];
          w_conv_data_nxt = w_grant[1] ? data1 : data0;
          w_conv_en_nxt   = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = LOAD;
        end
      end
      LOAD: begin
        if (r_cnt == LOAD_LAST) begin
          w_conv_en_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = CONVERT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      CONVERT: begin
        // converter output is final on the last run cycle; reload it right away
        if (r_cnt == CONV_LAST) begin
          w_result_nxt  = conv_bcd;
          w_conv_en_nxt = 1'b1;
          w_state_nxt   = CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      CAPTURE: begin
        w_done_nxt  = r_owner ? 2'b10 : 2'b01;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_ack       <= 2'b00;
      r_done      <= 2'b00;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_conv_en   <= 1'b1;
      r_conv_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_ack       <= w_ack_nxt;
      r_done      <= w_done_nxt;
      r_result    <= w_result_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_conv_en   <= w_conv_en_nxt;
      r_conv_data <= w_conv_data_nxt;
    end
  end

  assign ack0        = r_ack[0];
  assign ack1        = r_ack[1];
  assign done0       = r_done[0];
  assign done1       = r_done[1];
  assign result      = r_result;
  assign busy        = r_busy;
  assign conv_enable = r_conv_en;
  assign conv_data   = r_conv_data;
endmodule
